ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter; the send-side counterpart to the PS/2 frame receiver. Accepts one byte from the game controller logic and performs the full host request sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop and device ACK. Runs on the system clock and samples the PS/2 lines through synchronizers. Drives the open-drain PS/2 clock and data pads via active-high pull-low enables.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_sync.sv | 34 +++
 rtl/ps2_transmitter.sv | 196 +++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame constants and default timing for the
// transmitter and the matching receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      REQ,
      WAIT_IDLE
   } ps2_state_e;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned ACK_EDGE  = 11;

   // 50 MHz system clock: 100 us inhibit, 15 ms request-to-ACK limit
   localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;
   localparam int unsigned DEF_SYNC_STAGES    = 2;

   function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// N-stage synchronizer for one PS/2 pad plus a falling-edge detector on the
// synchronized value. Flops reset high to match an idle (pulled-up) line.
module ps2_line_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic line_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = (sync_q << 1) | STAGES'(line_i);
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign line_o = sync_q[STAGES-1];
   assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 8 data bits LSB
// first, odd parity, stop and ACK check, with a request-to-ACK timeout.
module ps2_transmitter
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic       CLK,
   input  logic       Resetn,
   input  logic       Start,
   input  logic [7:0] TxData,
   output logic       Busy,
   output logic       Done,
   output logic       Error,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

   // Edge thresholds compared against the count before the current fall
   localparam logic [3:0] EdgeParity = 4'(DATA_BITS);
   localparam logic [3:0] EdgeStop   = 4'(DATA_BITS + 1);
   localparam logic [3:0] EdgeAck    = 4'(ACK_EDGE - 1);

   ps2_state_e       state_q, state_d;
   logic [InhW-1:0]  inh_q, inh_d;
   logic [ToW-1:0]   to_q, to_d, to_next;
   logic [3:0]       edge_q, edge_d;
   logic [7:0]       data_q, data_d;
   logic             par_q, par_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;

   logic clk_sync, clk_fall, data_sync, data_fall_unused;

   ps2_line_sync #(
      .STAGES (SYNC_STAGES)
   ) u_clk_sync (
      .clk    (CLK),
      .rst_n  (Resetn),
      .line_i (ps2_clk_in),
      .line_o (clk_sync),
      .fall_o (clk_fall)
   );

   ps2_line_sync #(
      .STAGES (SYNC_STAGES)
   ) u_data_sync (
      .clk    (CLK),
      .rst_n  (Resetn),
      .line_i (ps2_data_in),
      .line_o (data_sync),
      .fall_o (data_fall_unused)
   );

   always_comb begin
      state_d   = state_q;
      inh_d     = inh_q;
      to_d      = to_q;
      to_next   = to_q + 1'b1;
      edge_d    = edge_q;
      data_d    = data_q;
      par_d     = par_q;
      busy_d    = (state_q != IDLE);
      done_d    = 1'b0;
      error_d   = 1'b0;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;

      unique case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (Start) begin
               data_d   = TxData;
               par_d    = odd_parity(TxData);
               inh_d    = InhW'(INHIBIT_CYCLES - 1);
               busy_d   = 1'b1;
               clk_oe_d = 1'b1;
               state_d  = INHIBIT;
            end
         end

         INHIBIT: begin
            if (inh_q == '0) begin
               data_oe_d = 1'b1;
               state_d   = START;
            end else begin
               inh_d = inh_q - 1'b1;
            end
         end

         START: begin
            clk_oe_d = 1'b0;
            edge_d   = '0;
            to_d     = '0;
            state_d  = REQ;
         end

         REQ: begin
            // Timeout is checked first so it wins over a same-cycle ACK sample
            if (to_next == ToW'(TIMEOUT_CYCLES)) begin
               error_d   = 1'b1;
               data_oe_d = 1'b0;
               state_d   = IDLE;
            end else begin
               to_d = to_next;
               if (clk_fall) begin
                  if (edge_q != 4'hF) begin
                     edge_d = edge_q + 1'b1;
                  end
                  if (edge_q < EdgeParity) begin
                     data_oe_d = ~data_q[edge_q[2:0]];
                  end else if (edge_q == EdgeParity) begin
                     data_oe_d = ~par_q;
                  end else if (edge_q == EdgeStop) begin
                     data_oe_d = 1'b0;
                  end else if (edge_q == EdgeAck) begin
                     data_oe_d = 1'b0;
                     if (data_sync) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                     end else begin
                        state_d = WAIT_IDLE;
                     end
                  end
               end
            end
         end

         WAIT_IDLE: begin
            if (to_next == ToW'(TIMEOUT_CYCLES)) begin
               error_d   = 1'b1;
               data_oe_d = 1'b0;
               state_d   = IDLE;
            end else begin
               to_d = to_next;
               if (clk_sync && data_sync) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         inh_q     <= '0;
         to_q      <= '0;
         edge_q    <= '0;
         data_q    <= '0;
         par_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_q     <= inh_d;
         to_q      <= to_d;
         edge_q    <= edge_d;
         data_q    <= data_d;
         par_q     <= par_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
      end
   end

   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Error       = error_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-drain bus model, PS/2 device model and a
// scoreboard of expected frame bits and outcomes.
module tb_ps2_transmitter;

   localparam int unsigned INH  = 20;
   localparam int unsigned TO   = 3000;
   localparam int unsigned HALF = 25;

   typedef struct {
      logic [10:0] bits;
      bit          done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       busy, done, error, clk_oe, data_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_line, ps2_data_line;

   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
   assign ps2_data_line = ~(data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_transmitter #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO),
      .SYNC_STAGES    (2)
   ) dut (
      .CLK         (clk),
      .Resetn      (rst_n),
      .Start       (start),
      .TxData      (tx_data),
      .Busy        (busy),
      .Done        (done),
      .Error       (error),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_data_in (ps2_data_line),
      .ps2_clk_oe  (clk_oe),
      .ps2_data_oe (data_oe)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("%s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wire order as seen by the device: start, D0..D7, odd parity, stop
   function automatic logic [10:0] frame_bits(input logic [7:0] d);
      logic par;
      par = ($countones(d) % 2) == 0;
      return {1'b1, par, d, 1'b0};
   endfunction

   task automatic drive_start(input logic [7:0] d);
      @(negedge clk);
      start   = 1'b1;
      tx_data = d;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // mode 0: ACK at edge 11, mode 1: no ACK, mode 2: device silent
   task automatic device(input int mode, input int abort_edge, output logic [10:0] bits);
      bits = '0;
      if (mode == 2) return;
      for (int w = 0; w < int'(INH) + 50 && clk_oe; w++) @(negedge clk);
      check("dev_sees_release", {31'b0, clk_oe}, 0);
      if (clk_oe) return;
      repeat (10) @(negedge clk);
      bits[0] = ps2_data_line;
      for (int k = 1; k <= 11; k++) begin
         if (k == 11 && mode == 0) dev_data_low = 1'b1;
         repeat (5) @(negedge clk);
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         if (k == abort_edge) begin
            check("pre_reset_data_oe", {31'b0, data_oe}, 1);
            rst_n = 1'b0;
            #1;
            check("async_rst_clk_oe", {31'b0, clk_oe}, 0);
            check("async_rst_data_oe", {31'b0, data_oe}, 0);
            check("async_rst_busy", {31'b0, busy}, 0);
            dev_clk_low = 1'b0;
            return;
         end
         dev_clk_low = 1'b0;
         if (k <= 10) bits[k] = ps2_data_line;
         repeat (HALF) @(negedge clk);
      end
      dev_data_low = 1'b0;
   endtask

   task automatic monitor(input bit inject, output int oe_cycles, output int fall_to_err,
                          output bit got_done, output bit got_err);
      int  fall_idx = -1;
      int  busy_low = 0;
      bit  prev_oe = 1'b1;
      bit  ended = 1'b0;
      oe_cycles   = 0;
      fall_to_err = -1;
      got_done    = 1'b0;
      got_err     = 1'b0;
      for (int i = 0; i < int'(INH + TO) + 200 && !ended; i++) begin
         if (clk_oe) oe_cycles++;
         if (prev_oe && !clk_oe && fall_idx < 0) fall_idx = i;
         prev_oe = clk_oe;
         if (!busy) busy_low++;
         if (done || error) begin
            got_done    = done;
            got_err     = error;
            fall_to_err = i - fall_idx;
            ended       = 1'b1;
            check("busy_low_during_frame", busy_low, 0);
            @(negedge clk);
            check("busy_after_pulse", {31'b0, busy}, 0);
            check("pulse_single", {30'b0, done, error}, 0);
            check("lines_released", {30'b0, clk_oe, data_oe}, 0);
         end else begin
            if (inject && i == 5) begin
               start   = 1'b1;
               tx_data = 8'h12;
            end else if (inject && i == 6) begin
               start = 1'b0;
            end
            @(negedge clk);
         end
      end
      check("frame_ended_in_bound", {31'b0, ended}, 1);
   endtask

   task automatic run_frame(input logic [7:0] d, input int mode, input bit inject);
      exp_t        e;
      logic [10:0] bits;
      int          oe_cycles, fall_to_err;
      bit          got_done, got_err;
      sb.push_back('{bits: frame_bits(d), done: (mode == 0)});
      drive_start(d);
      check("busy_after_start", {31'b0, busy}, 1);
      fork
         monitor(inject, oe_cycles, fall_to_err, got_done, got_err);
         device(mode, 0, bits);
      join
      e = sb.pop_front();
      check("outcome_done", {31'b0, got_done}, {31'b0, e.done});
      check("outcome_error", {31'b0, got_err}, {31'b0, !e.done});
      check("clk_oe_high_cycles", oe_cycles, INH + 1);
      if (mode != 2) check("frame_bits", {21'b0, bits}, {21'b0, e.bits});
      else check("timeout_latency", fall_to_err, TO);
      repeat (20) @(negedge clk);
      check("idle_after_frame", {30'b0, busy, clk_oe}, 0);
   endtask

   initial begin
      logic [10:0] dummy;
      repeat (4) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_clk_oe", {31'b0, clk_oe}, 0);
      check("idle_data_oe", {31'b0, data_oe}, 0);
      check("idle_busy", {31'b0, busy}, 0);
      check("idle_done", {31'b0, done}, 0);
      check("idle_error", {31'b0, error}, 0);

      run_frame(8'hF4, 0, 1'b0);
      run_frame(8'h00, 0, 1'b0);
      run_frame(8'hFF, 0, 1'b0);
      run_frame(8'hA5, 1, 1'b0);
      run_frame(8'h3C, 2, 1'b0);
      run_frame(8'hF4, 0, 1'b1);

      // Bit 4 of 0xE5 is 0, so data is being pulled low when reset hits at edge 5
      drive_start(8'hE5);
      device(0, 5, dummy);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_frame(8'hF4, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
